// File: rtl/systolic_drain_if.sv
// Bus bundle for the systolic result-drain stage: tile capture handshake on one side,
// element stream with saturation status on the other.
interface systolic_drain_if #(
  parameter int ACCUM_WIDTH = 16,
  parameter int T           = 16,
  parameter int OUT_WIDTH   = 8
);
  localparam int CW = $clog2(T);
  localparam int SW = $clog2(T * T) + 1;

  logic                         tile_valid;
  logic                         tile_ready;
  logic [ACCUM_WIDTH*T*T-1:0]   tile_data;
  logic [OUT_WIDTH-1:0]         c_data;
  logic                         c_valid;
  logic                         c_ready;
  logic [CW-1:0]                c_row;
  logic [CW-1:0]                c_col;
  logic                         c_last;
  logic                         c_sat;
  logic [SW-1:0]                sat_count;
  logic                         done;

  // slave is the drain stage's own view; master is the surrounding system.
  modport slave (
    input  tile_valid, tile_data, c_ready,
    output tile_ready, c_data, c_valid, c_row, c_col, c_last, c_sat, sat_count, done
  );

  modport master (
    output tile_valid, tile_data, c_ready,
    input  tile_ready, c_data, c_valid, c_row, c_col, c_last, c_sat, sat_count, done
  );
endinterface

// File: rtl/systolic_drain.sv
// Captures a full T x T accumulator tile in one cycle and streams it out row-major,
// narrowing each element to OUT_WIDTH bits with unsigned saturation.
module systolic_drain #(
  parameter int ACCUM_WIDTH = 16,
  parameter int T           = 16,
  parameter int OUT_WIDTH   = 8
) (
  input  logic             clk,
  input  logic             rst,
  systolic_drain_if.slave  bus
);
  localparam int N  = T * T;
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(T);
  localparam int SW = IW + 1;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_e;

  state_e                          state_q, state_d;
  logic [N-1:0][ACCUM_WIDTH-1:0]   buf_q;
  logic [CW-1:0]                   row_q, row_d;
  logic [CW-1:0]                   col_q, col_d;
  logic [SW-1:0]                   sat_q, sat_d;

  logic                            streaming;
  logic                            capture;
  logic [IW-1:0]                   idx;
  logic [ACCUM_WIDTH-1:0]          elem;
  logic                            over;

  assign streaming = (state_q == STREAM);
  assign capture   = (state_q == IDLE) && bus.tile_valid;
  assign idx       = IW'(row_q) * IW'(T) + IW'(col_q);
  assign elem      = buf_q[idx];

  generate
    if (OUT_WIDTH < ACCUM_WIDTH) begin : g_sat
      assign over = |elem[ACCUM_WIDTH-1:OUT_WIDTH];
    end else begin : g_nosat
      assign over = 1'b0;
    end
  endgenerate

  // Outputs are forced to zero outside STREAM so the unreset buffer never leaks X.
  assign bus.tile_ready = (state_q == IDLE);
  assign bus.c_valid    = streaming;
  assign bus.done       = (state_q == DONE);
  assign bus.c_sat      = streaming && over;
  assign bus.c_data     = !streaming ? '0 : (over ? '1 : elem[OUT_WIDTH-1:0]);
  assign bus.c_row      = row_q;
  assign bus.c_col      = col_q;
  assign bus.c_last     = streaming && (row_q == CW'(T - 1)) && (col_q == CW'(T - 1));
  assign bus.sat_count  = sat_q;

  // NOTE: every variable gets its default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    sat_d   = sat_q;
    unique case (state_q)
      IDLE: begin
        if (bus.tile_valid) begin
          state_d = STREAM;
          row_d   = '0;
          col_d   = '0;
          sat_d   = '0;
        end
      end
      STREAM: begin
        if (bus.c_ready) begin
          sat_d = sat_q + SW'(over);
          if (col_q == CW'(T - 1)) begin
            col_d = '0;
            row_d = (row_q == CW'(T - 1)) ? '0 : row_q + CW'(1);
            if (row_q == CW'(T - 1)) state_d = DONE;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      sat_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      sat_q   <= sat_d;
    end
  end

  // NOTE: the tile buffer is deliberately not reset; it is only read after a capture.
  always_ff @(posedge clk) begin
    if (capture) buf_q <= bus.tile_data;
  end
endmodule

// File: tb/tb_systolic_drain.sv
// Directed bench for systolic_drain: table of whole-tile runs plus hand-written
// sequences for a tile offered mid-stream and an asynchronous reset mid-stream.
module tb_systolic_drain;
  localparam int AW = 16;
  localparam int T  = 16;
  localparam int OW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  systolic_drain_if #(.ACCUM_WIDTH(AW), .T(T), .OUT_WIDTH(OW)) bus ();

  systolic_drain #(.ACCUM_WIDTH(AW), .T(T), .OUT_WIDTH(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string name;
    int    pat;
    int    mode;
    int    exp_sat;
    int    exp_cyc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference element value for each stimulus pattern.
  function automatic int elem(input int pat, input int r, input int c);
    case (pat)
      0:       return (r == c) ? 1 : 0;
      1:       return r * 16 + c;
      2:       return 300;
      3:       return (r == 0 && c == 0) ? 255 : ((r == 0 && c == 1) ? 256 : 0);
      default: return 0;
    endcase
  endfunction

  function automatic logic [AW*T*T-1:0] make_tile(input int pat);
    logic [AW*T*T-1:0] t;
    t = '0;
    for (int r = 0; r < T; r++)
      for (int c = 0; c < T; c++)
        t[AW*(r*T+c) +: AW] = AW'(elem(pat, r, c));
    return t;
  endfunction

  function automatic logic [31:0] pack(input bit tr, input bit v, input int row, input int col,
                                       input bit last, input bit sat, input int data,
                                       input int satcnt, input bit dn);
    return {2'b0, tr, v, 4'(row), 4'(col), last, sat, 8'(data), 9'(satcnt), dn};
  endfunction

  function automatic logic [31:0] act_pack();
    return {2'b0, bus.tile_ready, bus.c_valid, bus.c_row, bus.c_col, bus.c_last,
            bus.c_sat, bus.c_data, bus.sat_count, bus.done};
  endfunction

  // Offers a tile and returns one cycle after the capture edge with tile_valid dropped.
  task automatic capture_tile(input int pat, input string name);
    int waited = 0;
    @(negedge clk);
    while (!bus.tile_ready && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 1000) check({name, " tile_ready timeout"}, 32'(waited), 32'd0);
    bus.tile_valid = 1'b1;
    bus.tile_data  = make_tile(pat);
    @(posedge clk); #1;
    bus.tile_valid = 1'b0;
  endtask

  // mode 0: c_ready held high; mode 1: c_ready toggles 1,0,1,0...
  task automatic stream_tile(input int pat, input int mode, input int exp_sat, input int exp_cyc,
                             input int offer_pat, input int abort_at, input string name);
    int e = 0, cyc = 0, sc = 0, v, r, c;
    bit s;
    while (e < T * T) begin
      if (cyc >= 2000) begin
        check({name, " stream timeout"}, 32'(cyc), 32'(exp_cyc));
        break;
      end
      if (offer_pat >= 0 && e == 10) begin
        bus.tile_valid = 1'b1;
        bus.tile_data  = make_tile(offer_pat);
      end
      bus.c_ready = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
      @(negedge clk);
      r = e / T;
      c = e % T;
      v = elem(pat, r, c);
      s = (v > 255);
      check($sformatf("%s beat%0d cyc%0d", name, e, cyc), act_pack(),
            pack(0, 1, r, c, e == T*T-1, s, s ? 255 : v, sc, 0));
      if (abort_at == e) return;
      if (bus.c_ready) begin
        sc += int'(s);
        e++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.c_ready = 1'b0;
    check({name, " cycles"}, 32'(cyc), 32'(exp_cyc));
    @(negedge clk);
    check({name, " done"}, act_pack(), pack(0, 0, 0, 0, 0, 0, 0, exp_sat, 1));
    @(posedge clk); #1;
    @(negedge clk);
    check({name, " idle"}, act_pack(), pack(1, 0, 0, 0, 0, 0, 0, exp_sat, 0));
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{name: "identity",   pat: 0, mode: 0, exp_sat: 0,   exp_cyc: 256};
    vecs[1] = '{name: "ramp",       pat: 1, mode: 0, exp_sat: 0,   exp_cyc: 256};
    vecs[2] = '{name: "all300",     pat: 2, mode: 0, exp_sat: 256, exp_cyc: 256};
    vecs[3] = '{name: "ramp_bp",    pat: 1, mode: 1, exp_sat: 0,   exp_cyc: 511};
    vecs[4] = '{name: "boundary",   pat: 3, mode: 0, exp_sat: 1,   exp_cyc: 256};

    bus.tile_valid = 1'b0;
    bus.tile_data  = '0;
    bus.c_ready    = 1'b0;
    rst            = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset held", act_pack(), pack(1, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset released", act_pack(), pack(1, 0, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < 5; i++) begin
      capture_tile(vecs[i].pat, vecs[i].name);
      stream_tile(vecs[i].pat, vecs[i].mode, vecs[i].exp_sat, vecs[i].exp_cyc, -1, -1, vecs[i].name);
    end

    // A second tile held valid from beat 10 must wait until the first IDLE cycle.
    capture_tile(1, "offer_first");
    stream_tile(1, 0, 0, 256, 0, -1, "offer_first");
    @(posedge clk); #1;
    bus.tile_valid = 1'b0;
    stream_tile(0, 0, 0, 256, -1, -1, "offer_second");

    // Asynchronous reset in the middle of a saturating tile.
    capture_tile(2, "rst_mid");
    stream_tile(2, 0, 0, 0, -1, 100, "rst_mid");
    #2 rst = 1'b0;
    #1 check("rst_mid async clear", act_pack(), pack(1, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid after release", act_pack(), pack(1, 0, 0, 0, 0, 0, 0, 0, 0));
    capture_tile(1, "post_rst");
    stream_tile(1, 0, 0, 256, -1, -1, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/systolic_drain.md
# systolic_drain

Downstream result-drain stage for the systolic matrix-multiply core. Captures one completed T×T tile of packed accumulator results in a single cycle, then streams it out element by element in row-major order over a valid/ready handshake. Each accumulator is narrowed to OUT_WIDTH bits with unsigned saturation, and the stage counts how many elements saturated per tile. It sits between the array's packed `out` bus and the result writer or host stream.

## Interface
- `ACCUM_WIDTH`, 16: width of one accumulator element in the packed input.
- `T`, 16: tile dimension; a tile holds T*T elements.
- `OUT_WIDTH`, 8: width of the streamed output element. Must be ≤ ACCUM_WIDTH.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `tile_valid`  in  1: `tile_data` holds a complete tile.
- `tile_ready`  out  1: stage can accept a tile (IDLE only).
- `tile_data`  in  ACCUM_WIDTH*T*T: packed tile.
  - Element (r,c) sits at bits `[ACCUM_WIDTH*(r*T+c) +: ACCUM_WIDTH]`, unsigned.
- `c_data`  out  OUT_WIDTH: current streamed element, saturated.
- `c_valid`  out  1: `c_data`, `c_row`, `c_col`, `c_last`, `c_sat` are valid.
- `c_ready`  in  1: consumer accepts the current beat.
- `c_row`, `c_col`  out  $clog2(T) each: coordinates of the current beat.
- `c_last`  out  1: current beat is element (T-1,T-1).
- `c_sat`  out  1: current beat was saturated.
- `sat_count`  out  $clog2(T*T)+1: number of saturated elements in the last or current tile.
- `done`  out  1: one-cycle pulse after the final beat transfers.

## Operation
- States: IDLE, STREAM, DONE.
- IDLE:
  - `tile_ready`=1.
  - On `tile_valid && tile_ready`, register all of `tile_data` into the internal tile buffer, zero the index and `sat_count`, and go to STREAM.
- STREAM:
  - `c_valid`=1.
  - Outputs reflect the buffer element at index `idx` = `c_row`*T + `c_col`.
  - A transfer occurs on `c_valid && c_ready`. On a transfer:
    - `c_col` increments and wraps T-1→0; `c_row` increments on that wrap.
    - `sat_count` increments if the transferred beat had `c_sat`=1.
  - After the transfer of idx = T*T-1, go to DONE.
- DONE: `c_valid`=0, `tile_ready`=0, `done`=1 for exactly one cycle, then go to IDLE.
- Saturation (unsigned):
  - If element > 2^OUT_WIDTH−1: `c_data` = all ones, `c_sat`=1.
  - Otherwise: `c_data` = element[OUT_WIDTH-1:0], `c_sat`=0.
  - `c_sat` is combinational from the buffered element and `idx`.
  - `sat_count` is registered.
- Stall: while `c_valid && !c_ready`, all `c_*` outputs hold stable. No beat is dropped or duplicated.
- `tile_valid` in STREAM or DONE is ignored; `tile_ready`=0 in those states. The upstream holds the tile until accepted.
- `sat_count` holds its final value through DONE and IDLE until the next capture clears it.
- `sat_count` never overflows: its maximum is T*T.

## Timing
- Reset values (asynchronous on `rst`=0; any in-flight tile is discarded):
  - state=IDLE, `tile_ready`=1 after reset is released.
  - `c_valid`=0, `c_data`=0, `c_row`=0, `c_col`=0, `c_last`=0, `c_sat`=0, `sat_count`=0, `done`=0.
  - Buffer contents don't-care.
- Capture at edge k → `c_valid`=1 with element (0,0) from edge k onward (first beat presented in cycle k+1).
- With `c_ready` held at 1: one beat per cycle. The last beat transfers at edge k+T*T, `done` is high after that edge for one cycle, and `tile_ready`=1 again after edge k+T*T+1.
- Back-to-back tiles: minimum spacing between captures is T*T+2 cycles.
- `c_ready` may toggle arbitrarily; throughput equals the number of cycles with `c_ready`=1 in STREAM.
- `tile_ready` is a registered state decode; it does not depend combinationally on `tile_valid`.
- `c_last`=1 exactly when `c_row`=T-1, `c_col`=T-1, and `c_valid`=1.

## Test plan
- Identity tile: element (r,c) = (r==c)?1:0, `c_ready`=1.
  - 256 beats with `c_data`=1 only where `c_row`==`c_col`.
  - `c_last` on beat 255, `done` pulse one cycle later, `sat_count`=0.
- Saturation tile: element (r,c) = r*16+c (0..255 fit in 8 bits), then a second tile with every element = 300.
  - First tile: all `c_sat`=0, `sat_count`=0.
  - Second tile: `c_data`=255 on every beat, `sat_count`=256.
- Backpressure: `c_ready` toggles 1,0,1,0… over a ramp tile.
  - Beats arrive in order 0..255 with no drops or duplicates.
  - Outputs are stable in every stalled cycle.
  - Last transfer occurs about 512 cycles after capture.
- Second tile offered during STREAM: `tile_valid`=1 held from beat 10.
  - `tile_ready` stays 0 until after `done`.
  - The second tile is captured in the first IDLE cycle and its element (0,0) follows.
- Reset mid-stream: assert `rst`=0 at beat 100.
  - `c_valid`=0, `c_row`=`c_col`=0, `sat_count`=0 immediately, without waiting for a clock edge.
  - After release, `tile_ready`=1 and a fresh tile streams from (0,0).
- Boundary element: element (0,0) = 255 and (0,1) = 256.
  - Beat 0 gives `c_data`=255, `c_sat`=0.
  - Beat 1 gives `c_data`=255, `c_sat`=1, and `sat_count` ends at 1.
